// File: rtl/id_ex_issue.sv
// id_ex_issue: decode/issue stage feeding the one-hot ALU execute stage.
//   Reads a 32x32 register file with writeback write-through, tracks pending
//   destinations in a scoreboard and stalls on RAW/WAW hazards. Issue latency
//   is one cycle. Back-to-back issue is possible, and stalls come from hazards
//   or from ex_ready=0.
// Optional feature: define WB_BYPASS_EN to forward wb_data to same-cycle reads
//   and unblock a hazard in the writeback cycle, with zero bubbles.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   instr_valid/instr  instruction {funct[17:15], rd[14:10], rs1[9:5], rs2[4:0]}
//   instr_ready        combinational, asserted when the instruction can be accepted this cycle
//   ex_ready           execute stage can take an op this cycle
//   wb_en/addr/data    register writeback
//   ID_EX_A/B          registered operands
//   opcode             registered one-hot op
//   ex_rd              registered destination
//   load               one-cycle issue strobe
//   illegal            one-cycle pulse when an illegal funct was consumed
module id_ex_issue #(
  parameter int NREG = 32,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic [17:0]     instr,
  output logic            instr_ready,
  input  logic            ex_ready,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] ID_EX_A,
  output logic [XLEN-1:0] ID_EX_B,
  output logic [5:0]      opcode,
  output logic            load,
  output logic [4:0]      ex_rd,
  output logic            illegal
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] sb;
  logic [NREG-1:0] sb_nxt;

  logic [2:0]      funct;
  logic [4:0]      rd, rs1, rs2;
  logic            wb_hit;
  logic            byp_rd, byp_rs1, byp_rs2;
  logic            pend_rd, pend_rs1, pend_rs2;
  logic            hazard, accept, legal;
  logic [5:0]      onehot;
  logic [XLEN-1:0] val_a, val_b;

  assign funct  = instr[17:15];
  assign rd     = instr[14:10];
  assign rs1    = instr[9:5];
  assign rs2    = instr[4:0];
  assign wb_hit = wb_en & (wb_addr != 5'd0);

`ifdef WB_BYPASS_EN
  // A writeback landing this cycle both forwards its value and retires the
  // pending bit early, so a waiting consumer issues without a bubble.
  assign byp_rd  = wb_hit & (wb_addr == rd);
  assign byp_rs1 = wb_hit & (wb_addr == rs1);
  assign byp_rs2 = wb_hit & (wb_addr == rs2);
`else
  assign byp_rd  = 1'b0;
  assign byp_rs1 = 1'b0;
  assign byp_rs2 = 1'b0;
`endif

  assign pend_rd  = sb[rd]  & (rd  != 5'd0) & ~byp_rd;
  assign pend_rs1 = sb[rs1] & (rs1 != 5'd0) & ~byp_rs1;
  assign pend_rs2 = sb[rs2] & (rs2 != 5'd0) & ~byp_rs2;

  assign hazard      = pend_rd | pend_rs1 | pend_rs2;
  assign instr_ready = ex_ready & ~hazard;
  assign accept      = instr_valid & instr_ready;

  always_comb begin
    onehot = 6'b000000;
    legal  = 1'b1;
    case (funct)
      3'd0:    onehot = 6'b000001;
      3'd1:    onehot = 6'b000010;
      3'd2:    onehot = 6'b000100;
      3'd3:    onehot = 6'b001000;
      3'd4:    onehot = 6'b010000;
      3'd5:    onehot = 6'b100000;
      default: legal  = 1'b0;
    endcase
  end

  always_comb begin
    val_a = '0;
    if (rs1 != 5'd0) val_a = byp_rs1 ? wb_data : regs[rs1];
    val_b = '0;
    if (rs2 != 5'd0) val_b = byp_rs2 ? wb_data : regs[rs2];
  end

  // Clear on writeback first, then set on issue, so a coincident set wins.
  always_comb begin
    sb_nxt = sb;
    if (wb_hit) sb_nxt[wb_addr] = 1'b0;
    if (accept && legal && (rd != 5'd0)) sb_nxt[rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      sb      <= '0;
      ID_EX_A <= '0;
      ID_EX_B <= '0;
      opcode  <= '0;
      ex_rd   <= '0;
      load    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      if (wb_hit) regs[wb_addr] <= wb_data;
      sb      <= sb_nxt;
      load    <= accept & legal;
      illegal <= accept & ~legal;
      if (accept && legal) begin
        ID_EX_A <= val_a;
        ID_EX_B <= val_b;
        opcode  <= onehot;
        ex_rd   <= rd;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_issue.sv
// Directed bench for id_ex_issue: operand read, hazard stalls, x0 handling,
// illegal funct, backpressure and reset while stalled.
module tb_id_ex_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [17:0] instr;
  logic        instr_ready;
  logic        ex_ready;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] ID_EX_A, ID_EX_B;
  logic [5:0]  opcode;
  logic        load;
  logic [4:0]  ex_rd;
  logic        illegal;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  id_ex_issue dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .ex_ready(ex_ready), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data), .ID_EX_A(ID_EX_A), .ID_EX_B(ID_EX_B),
    .opcode(opcode), .load(load), .ex_rd(ex_rd), .illegal(illegal)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [17:0] mk(input int f, input int d, input int s1, input int s2);
    logic [2:0] ff;
    logic [4:0] dd, a, b;
    ff = 3'(f); dd = 5'(d); a = 5'(s1); b = 5'(s2);
    return {ff, dd, a, b};
  endfunction

  task automatic wb(input int a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = 5'(a); wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] op, input logic [4:0] d, input logic ld,
                         input logic il);
    chk({tag, ".A"},       ID_EX_A, a);
    chk({tag, ".B"},       ID_EX_B, b);
    chk({tag, ".opcode"},  32'(opcode), 32'(op));
    chk({tag, ".ex_rd"},   32'(ex_rd), 32'(d));
    chk({tag, ".load"},    32'(load), 32'(ld));
    chk({tag, ".illegal"}, 32'(illegal), 32'(il));
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr = '0; ex_ready = 1'b1;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk_out("reset", 0, 0, 6'd0, 5'd0, 1'b0, 1'b0);
    chk("reset.ready", 32'(instr_ready), 1);

    // Basic ADD after loading x3/x4.
    wb(3, 32'd100);
    wb(4, 32'hFFFF_FFF9);
    instr = mk(0, 5, 3, 4); instr_valid = 1'b1;
    #1 chk("add.ready", 32'(instr_ready), 1);
    tick();
    instr_valid = 1'b0;
    chk_out("add", 32'd100, 32'hFFFF_FFF9, 6'b000001, 5'd5, 1'b1, 1'b0);
    tick();
    chk("add.load_drop", 32'(load), 0);
    chk("add.A_hold", ID_EX_A, 32'd100);

    // RAW stall on x5.
    instr = mk(1, 6, 5, 3); instr_valid = 1'b1;
    #1 chk("raw.ready0", 32'(instr_ready), 0);
    tick();
    chk("raw.load0", 32'(load), 0);
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'd93;
    #1;
`ifdef WB_BYPASS_EN
    chk("raw.ready_byp", 32'(instr_ready), 1);
    tick();
    wb_en = 1'b0; instr_valid = 1'b0;
`else
    chk("raw.ready_wbcyc", 32'(instr_ready), 0);
    tick();
    wb_en = 1'b0;
    chk("raw.load_bubble", 32'(load), 0);
    #1 chk("raw.ready_after", 32'(instr_ready), 1);
    tick();
    instr_valid = 1'b0;
`endif
    chk_out("raw", 32'd93, 32'd100, 6'b000010, 5'd6, 1'b1, 1'b0);

    // x0: writes ignored, reads zero, never pending.
    wb(0, 32'd55);
    instr = mk(3, 0, 0, 3); instr_valid = 1'b1;
    #1 chk("x0.ready", 32'(instr_ready), 1);
    tick();
    chk_out("x0.or", 0, 32'd100, 6'b001000, 5'd0, 1'b1, 1'b0);
    instr = mk(0, 7, 0, 0);
    #1 chk("x0.next_ready", 32'(instr_ready), 1);
    tick();
    instr_valid = 1'b0;
    chk_out("x0.add", 0, 0, 6'b000001, 5'd7, 1'b1, 1'b0);

    // Illegal funct is consumed without issuing.
    instr = mk(7, 9, 3, 4); instr_valid = 1'b1;
    #1 chk("ill.ready", 32'(instr_ready), 1);
    tick();
    instr_valid = 1'b0;
    chk_out("ill", 0, 0, 6'b000001, 5'd7, 1'b0, 1'b1);
    tick();
    chk("ill.pulse_end", 32'(illegal), 0);

    // Backpressure with a hazard-free MUL (rs1=x9 must not be pending).
    ex_ready = 1'b0;
    instr = mk(5, 11, 9, 3); instr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp.ready0", 32'(instr_ready), 0);
      tick();
      chk("bp.load0", 32'(load), 0);
    end
    ex_ready = 1'b1;
    #1 chk("bp.ready1", 32'(instr_ready), 1);
    tick();
    instr_valid = 1'b0;
    chk_out("bp.mul", 0, 32'd100, 6'b100000, 5'd11, 1'b1, 1'b0);
    tick();
    chk("bp.once", 32'(load), 0);

    // Reset while stalled on x11.
    instr = mk(1, 12, 11, 3); instr_valid = 1'b1;
    #1 chk("rst.stall", 32'(instr_ready), 0);
    tick();
    chk("rst.stall_load", 32'(load), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_out("rst.mid", 0, 0, 6'd0, 5'd0, 1'b0, 1'b0);
    #1 chk("rst.ready", 32'(instr_ready), 1);
    tick();
    instr_valid = 1'b0;
    chk_out("rst.reissue", 0, 0, 6'b000010, 5'd12, 1'b1, 1'b0);

    // WAW: x12 now pending blocks a new writer of x12.
    instr = mk(0, 12, 0, 0); instr_valid = 1'b1;
    #1 chk("waw.ready0", 32'(instr_ready), 0);
    tick();
    wb_en = 1'b1; wb_addr = 5'd12; wb_data = 32'd5;
`ifdef WB_BYPASS_EN
    #1 chk("waw.ready_byp", 32'(instr_ready), 1);
    tick();
    wb_en = 1'b0;
    // Set and clear of x12 coincided: set wins, so x12 is still pending.
    #1 chk("waw.set_wins", 32'(instr_ready), 0);
    instr_valid = 1'b0;
`else
    #1 chk("waw.ready_wbcyc", 32'(instr_ready), 0);
    tick();
    wb_en = 1'b0;
    #1 chk("waw.ready_after", 32'(instr_ready), 1);
    tick();
    instr_valid = 1'b0;
    chk("waw.load", 32'(load), 1);
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
